// File: rtl/alu_seq_ctrl_if.sv
// alu_seq_ctrl_if: request/control bundle between the request source (master)
// and the ALU sequencing controller (slave). Carries the start/ready/done
// handshake, the per-request opcode and register selects, and the packed
// datapath control word returned by the controller.
interface alu_seq_ctrl_if #(
    parameter int ALU_W = 2,
    parameter int SEL_W = 4
);
    localparam int CTRL_W = ALU_W + 3 * SEL_W + 1;

    logic              i_start;
    logic [ALU_W-1:0]  i_op;
    logic [SEL_W-1:0]  i_src_a;
    logic [SEL_W-1:0]  i_src_b;
    logic [SEL_W-1:0]  i_dst;
    logic              o_ready;
    logic              o_busy;
    logic              o_done;
    logic [CTRL_W-1:0] o_signal;

    // Request source: drives the request, observes status and control word
    modport master (
        output i_start, i_op, i_src_a, i_src_b, i_dst,
        input  o_ready, o_busy, o_done, o_signal
    );

    // Controller: consumes the request, drives status and control word
    modport slave (
        input  i_start, i_op, i_src_a, i_src_b, i_dst,
        output o_ready, o_busy, o_done, o_signal
    );
endinterface

// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: Moore controller sequencing one register-to-register ALU
// operation per request: IDLE -> LOAD -> SETTLE x WAIT_CYC -> WRITE -> DONE.
// Control word o_signal = {alu, mux_a, mux_b, reg, w}, alu at the MSBs.
// Optional build macro ALU_SEQ_B2B_EN: accept a new request in DONE as well
// as IDLE (back-to-back operation). Undefined by default.
module alu_seq_ctrl #(
    parameter int ALU_W    = 2,
    parameter int SEL_W    = 4,
    parameter int WAIT_CYC = 2
) (
    input  logic           clk,
    input  logic           rst,
    alu_seq_ctrl_if.slave  ctrl_if
);
    localparam int CTRL_W = ALU_W + 3 * SEL_W + 1;

    // Settle counter is 8 bits wide, so WAIT_CYC must fit in 1..255
    generate
        if (WAIT_CYC < 1 || WAIT_CYC > 255) begin : g_bad_wait_cyc
            $error("alu_seq_ctrl: WAIT_CYC must be in 1..255");
        end
    endgenerate

    localparam logic [7:0] CNT_INIT = 8'(WAIT_CYC - 1);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LOAD   = 3'd1;
    localparam logic [2:0] ST_SETTLE = 3'd2;
    localparam logic [2:0] ST_WRITE  = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;

`ifdef ALU_SEQ_B2B_EN
    localparam logic B2B_EN = 1'b1;
`else
    localparam logic B2B_EN = 1'b0;
`endif

    logic [2:0]       state_q, state_d;
    logic [ALU_W-1:0] op_q, op_d;
    logic [SEL_W-1:0] src_a_q, src_a_d;
    logic [SEL_W-1:0] src_b_q, src_b_d;
    logic [SEL_W-1:0] dst_q, dst_d;
    logic [7:0]       cnt_q, cnt_d;

    logic ready;
    logic accept;

    // Ready depends only on the registered state; a request is taken when
    // the source asserts start while ready
    always_comb begin
        ready = (state_q == ST_IDLE) || (B2B_EN && (state_q == ST_DONE));
        accept = ready && ctrl_if.i_start;
    end

    // Next-state, operand capture and settle-counter logic
    always_comb begin
        state_d = ST_IDLE;
        op_d    = op_q;
        src_a_d = src_a_q;
        src_b_d = src_b_q;
        dst_d   = dst_q;
        cnt_d   = cnt_q;

        // Capture happens only on acceptance; captured values otherwise hold
        if (accept) begin
            op_d    = ctrl_if.i_op;
            src_a_d = ctrl_if.i_src_a;
            src_b_d = ctrl_if.i_src_b;
            dst_d   = ctrl_if.i_dst;
        end

        case (state_q)
            ST_IDLE: begin
                state_d = accept ? ST_LOAD : ST_IDLE;
            end
            ST_LOAD: begin
                cnt_d   = CNT_INIT;
                state_d = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (cnt_q == 8'd0) begin
                    state_d = ST_WRITE;
                end else begin
                    cnt_d   = cnt_q - 8'd1;
                    state_d = ST_SETTLE;
                end
            end
            ST_WRITE: begin
                state_d = ST_DONE;
            end
            ST_DONE: begin
                // accept can only be true here with back-to-back enabled
                state_d = accept ? ST_LOAD : ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and captured-request registers, cleared asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            op_q    <= '0;
            src_a_q <= '0;
            src_b_q <= '0;
            dst_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            src_a_q <= src_a_d;
            src_b_q <= src_b_d;
            dst_q   <= dst_d;
            cnt_q   <= cnt_d;
        end
    end

    // Moore output decode from registered state and captured request only
    always_comb begin
        ctrl_if.o_signal = '0;
        ctrl_if.o_ready  = ready;
        ctrl_if.o_busy   = 1'b0;
        ctrl_if.o_done   = 1'b0;
        case (state_q)
            ST_LOAD, ST_SETTLE: begin
                ctrl_if.o_signal = {op_q, src_a_q, src_b_q, {SEL_W{1'b0}}, 1'b0};
                ctrl_if.o_busy   = 1'b1;
            end
            ST_WRITE: begin
                ctrl_if.o_signal = {op_q, src_a_q, src_b_q, dst_q, 1'b1};
                ctrl_if.o_busy   = 1'b1;
            end
            ST_DONE: begin
                ctrl_if.o_done = 1'b1;
            end
            default: begin
                ctrl_if.o_signal = '0;
            end
        endcase
    end

    logic unused_ok;
    assign unused_ok = ^{CTRL_W[0]};
endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb_alu_seq_ctrl: three controller instances (WAIT_CYC = 2, 1, 5) share one
// request stream. A timeline model (cycles elapsed since acceptance) predicts
// every output of every instance and is compared each cycle at the falling
// edge; directed sequences pin the model with hand-computed control words.
module tb_alu_seq_ctrl;
`ifdef ALU_SEQ_B2B_EN
    localparam bit B2B = 1'b1;
`else
    localparam bit B2B = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       start_r = 1'b0;
    logic [1:0] op_r = '0;
    logic [3:0] a_r = '0;
    logic [3:0] b_r = '0;
    logic [3:0] d_r = '0;

    logic [2:0][14:0] sig_v;
    logic [2:0]       rdy_v;
    logic [2:0]       busy_v;
    logic [2:0]       done_v;

    int errors = 0;
    int checks = 0;

    function automatic int wv(input int i);
        return (i == 0) ? 2 : ((i == 1) ? 1 : 5);
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_dut
            localparam int WC = (gi == 0) ? 2 : ((gi == 1) ? 1 : 5);
            alu_seq_ctrl_if #(.ALU_W(2), .SEL_W(4)) ifc ();
            assign ifc.i_start = start_r;
            assign ifc.i_op    = op_r;
            assign ifc.i_src_a = a_r;
            assign ifc.i_src_b = b_r;
            assign ifc.i_dst   = d_r;
            assign sig_v[gi]   = ifc.o_signal;
            assign rdy_v[gi]   = ifc.o_ready;
            assign busy_v[gi]  = ifc.o_busy;
            assign done_v[gi]  = ifc.o_done;
            alu_seq_ctrl #(.ALU_W(2), .SEL_W(4), .WAIT_CYC(WC)) dut (
                .clk     (clk),
                .rst     (rst),
                .ctrl_if (ifc)
            );
        end
    endgenerate

    // Model: ph = cycles since acceptance (0 = idle). 1..W+1 load/settle,
    // W+2 write, W+3 done.
    int         ph [3];
    logic [1:0] op_m [3];
    logic [3:0] a_m [3];
    logic [3:0] b_m [3];
    logic [3:0] d_m [3];

    function automatic bit m_ready(input int i);
        return (ph[i] == 0) || (B2B && (ph[i] == wv(i) + 3));
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                ph[i]   <= 0;
                op_m[i] <= '0;
                a_m[i]  <= '0;
                b_m[i]  <= '0;
                d_m[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (start_r && m_ready(i)) begin
                    ph[i]   <= 1;
                    op_m[i] <= op_r;
                    a_m[i]  <= a_r;
                    b_m[i]  <= b_r;
                    d_m[i]  <= d_r;
                end else if (ph[i] == 0 || ph[i] >= wv(i) + 3) begin
                    ph[i] <= 0;
                end else begin
                    ph[i] <= ph[i] + 1;
                end
            end
        end
    end

    task automatic chk(input string name, input int inst, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s inst=%0d got=%0h expected=%0h t=%0t", name, inst, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        for (int i = 0; i < 3; i++) begin
            int         p;
            int         w;
            logic       wr;
            logic [14:0] e;
            p  = ph[i];
            w  = wv(i);
            wr = (p == w + 2);
            e  = '0;
            if (p >= 1 && p <= w + 2) e = {op_m[i], a_m[i], b_m[i], (wr ? d_m[i] : 4'd0), wr};
            chk("o_signal", i, 32'(sig_v[i]), 32'(e));
            chk("o_ready", i, 32'(rdy_v[i]), 32'(m_ready(i)));
            chk("o_busy", i, 32'(busy_v[i]), 32'(p >= 1 && p <= w + 2));
            chk("o_done", i, 32'(done_v[i]), 32'(p == w + 3));
        end
    endtask

    task automatic tick();
        @(negedge clk);
        compare_all();
    endtask

    task automatic req(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b, input logic [3:0] d);
        start_r = 1'b1;
        op_r = op;
        a_r = a;
        b_r = b;
        d_r = d;
    endtask

    task automatic idle_wait(input int n);
        start_r = 1'b0;
        for (int k = 0; k < n; k++) tick();
    endtask

    initial begin
        int          bcnt [3];
        int          widx [3];
        int          lastb [3];
        logic [14:0] hist [12];
        logic [11:0] dn0;
        logic [11:0] rd0;
        int          wcnt;
        int          dcnt;
        logic [14:0] wsig;

        // Reset state
        tick();
        tick();
        chk("reset_signal", 0, 32'(sig_v[0]), 32'h0);
        chk("reset_ready", 0, 32'(rdy_v[0]), 32'h1);
        chk("reset_busy", 0, 32'(busy_v[0]), 32'h0);
        chk("reset_done", 0, 32'(done_v[0]), 32'h0);
        #2 rst = 1'b0;
        tick();
        $display("txn: reset released");

        // Single request, latency and busy length on all three instances
        req(2'b01, 4'd3, 4'd5, 4'd9);
        for (int i = 0; i < 3; i++) begin
            bcnt[i] = 0;
            widx[i] = -1;
            lastb[i] = -1;
        end
        for (int c = 0; c < 12; c++) begin
            tick();
            start_r = 1'b0;
            hist[c] = sig_v[0];
            dn0[c] = done_v[0];
            rd0[c] = rdy_v[0];
            for (int i = 0; i < 3; i++) begin
                if (busy_v[i]) begin
                    bcnt[i]++;
                    lastb[i] = c;
                end
                if (sig_v[i][0]) widx[i] = c;
            end
        end
        chk("load_word", 0, 32'(hist[0]), 32'h26A0);
        chk("settle1_word", 0, 32'(hist[1]), 32'h26A0);
        chk("settle2_word", 0, 32'(hist[2]), 32'h26A0);
        chk("write_word", 0, 32'(hist[3]), 32'h26B3);
        chk("done_pulse", 0, 32'(dn0[4]), 32'h1);
        chk("done_word", 0, 32'(hist[4]), 32'h0);
        chk("idle_ready", 0, 32'(rd0[5]), 32'h1);
        chk("busy_len_w2", 0, 32'(bcnt[0]), 32'd4);
        chk("busy_len_w1", 1, 32'(bcnt[1]), 32'd3);
        chk("busy_len_w5", 2, 32'(bcnt[2]), 32'd7);
        for (int i = 0; i < 3; i++) chk("w_in_last_busy", i, 32'(widx[i]), 32'(lastb[i]));
        $display("txn: single request op=1 a=3 b=5 d=9 busy=%0d/%0d/%0d", bcnt[0], bcnt[1], bcnt[2]);

        // Inputs changing every cycle while busy: one write with captured values
        req(2'b01, 4'd3, 4'd5, 4'd9);
        wcnt = 0;
        wsig = '0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (sig_v[0][0]) begin
                wcnt++;
                wsig = sig_v[0];
            end
            if (c < 3) req(2'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
            else start_r = 1'b0;
        end
        chk("held_start_w_count", 0, 32'(wcnt), 32'd1);
        chk("held_start_write_word", 0, 32'(wsig), 32'h26B3);
        $display("txn: held start during busy, w pulses=%0d", wcnt);
        idle_wait(10);

        // Reset in second settle cycle aborts without write or done
        req(2'b01, 4'd3, 4'd5, 4'd9);
        tick();
        start_r = 1'b0;
        tick();
        tick();
        #2 rst = 1'b1;
        #1;
        chk("async_rst_signal", 0, 32'(sig_v[0]), 32'h0);
        chk("async_rst_busy", 0, 32'(busy_v[0]), 32'h0);
        chk("async_rst_ready", 0, 32'(rdy_v[0]), 32'h1);
        chk("async_rst_done", 0, 32'(done_v[0]), 32'h0);
        tick();
        #2 rst = 1'b0;
        wcnt = 0;
        dcnt = 0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (sig_v[0][0]) wcnt++;
            if (done_v[0]) dcnt++;
        end
        chk("aborted_w_count", 0, 32'(wcnt), 32'd0);
        chk("aborted_done_count", 0, 32'(dcnt), 32'd0);
        req(2'b11, 4'd1, 4'd2, 4'd7);
        wcnt = 0;
        dcnt = 0;
        wsig = '0;
        for (int c = 0; c < 8; c++) begin
            tick();
            start_r = 1'b0;
            if (sig_v[0][0]) begin
                wcnt++;
                wsig = sig_v[0];
            end
            if (done_v[0]) dcnt++;
        end
        chk("post_rst_w_count", 0, 32'(wcnt), 32'd1);
        chk("post_rst_done_count", 0, 32'(dcnt), 32'd1);
        chk("post_rst_write_word", 0, 32'(wsig), 32'h624F);
        $display("txn: reset mid-settle, then op=3 a=1 b=2 d=7 w=%0d done=%0d", wcnt, dcnt);
        idle_wait(10);

        // Second request presented in the DONE cycle
        req(2'b01, 4'd3, 4'd5, 4'd9);
        for (int c = 0; c < 5; c++) begin
            tick();
            start_r = 1'b0;
        end
        chk("done_before_b2b", 0, 32'(done_v[0]), 32'h1);
        req(2'b10, 4'd7, 4'd1, 4'd4);
        tick();
        start_r = 1'b0;
`ifdef ALU_SEQ_B2B_EN
        chk("b2b_load_word", 0, 32'(sig_v[0]), 32'h4E20);
        chk("b2b_busy", 0, 32'(busy_v[0]), 32'h1);
        wsig = '0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (sig_v[0][0]) wsig = sig_v[0];
        end
        chk("b2b_write_word", 0, 32'(wsig), 32'h4E29);
        $display("txn: back-to-back second request, write word=%0h", wsig);
`else
        chk("dropped_signal", 0, 32'(sig_v[0]), 32'h0);
        chk("dropped_ready", 0, 32'(rdy_v[0]), 32'h1);
        bcnt[0] = 0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (busy_v[0]) bcnt[0]++;
        end
        chk("dropped_busy_count", 0, 32'(bcnt[0]), 32'd0);
        $display("txn: request in DONE dropped, busy cycles after=%0d", bcnt[0]);
`endif
        idle_wait(10);

        // Randomised traffic with occasional asynchronous resets
        for (int c = 0; c < 3000; c++) begin
            tick();
            start_r = ($urandom_range(0, 99) < 40);
            op_r = 2'($urandom);
            a_r = 4'($urandom);
            b_r = 4'($urandom);
            d_r = 4'($urandom);
            if (rst) begin
                #2 rst = 1'b0;
            end else if ($urandom_range(0, 299) == 0) begin
                #2 rst = 1'b1;
            end
        end
        $display("txn: random traffic 3000 cycles");
        rst = 1'b0;
        idle_wait(10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
